// File: rtl/cpu_sequencer_if.sv
// Bus between the instruction sequencer and its ROM/RAM/ALU surroundings.
interface cpu_sequencer_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ROM_ADDR_WIDTH = 8,
    parameter int unsigned ROM_WIDTH      = 16
);
    logic [ROM_WIDTH-1:0]      rom_data;
    logic [DATA_WIDTH-1:0]     ram_data;
    logic                      zero_flag;
    logic                      sign_flag;
    logic                      carry_flag;
    logic                      stall;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr;
    logic                      fetch_ena;
    logic                      execute_ena;
    logic                      jump_ena;
    logic                      write_reg_ena;
    logic                      write_ram_ena;
    logic [3:0]                opcode;
    logic [1:0]                addr_mode;
    logic [7:0]                operand;
    logic [7:0]                eff_addr;
    logic                      halted;

    // Sequencer side.
    modport master (
        input  rom_data, ram_data, zero_flag, sign_flag, carry_flag, stall,
        output rom_addr, fetch_ena, execute_ena, jump_ena, write_reg_ena,
               write_ram_ena, opcode, addr_mode, operand, eff_addr, halted
    );

    // Memory / ALU side.
    modport slave (
        output rom_data, ram_data, zero_flag, sign_flag, carry_flag, stall,
        input  rom_addr, fetch_ena, execute_ena, jump_ena, write_reg_ena,
               write_ram_ena, opcode, addr_mode, operand, eff_addr, halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, optional indirect pointer
// load, execute with conditional jumps, and register/RAM writeback.
module cpu_sequencer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ROM_ADDR_WIDTH = 8,
    parameter int unsigned ROM_WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst,
    cpu_sequencer_if.master  bus
);
    localparam logic [1:0] MODE_INDIRECT = 2'b11;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JNZ  = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_JS   = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_STORE = 4'h2;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_INDIRECT, S_EXECUTE, S_WRITEBACK, S_HALT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [ROM_ADDR_WIDTH-1:0] r_pc;
    logic [ROM_ADDR_WIDTH-1:0] w_pc_next;
    logic [3:0]                r_opcode;
    logic [1:0]                r_addr_mode;
    logic [7:0]                r_operand;
    logic [7:0]                r_eff_addr;
    logic [7:0]                w_eff_next;
    logic [ROM_WIDTH-1:0]      w_instr;
    logic [DATA_WIDTH-1:0]     w_ram_data;
    logic                      w_taken;
    logic                      w_fetch;
    logic                      w_exec;
    logic                      w_wreg;
    logic                      w_wram;
    logic                      w_halted;
    logic                      w_unused_bits;

    assign w_instr       = bus.rom_data;
    assign w_ram_data    = bus.ram_data;
    assign w_unused_bits = ^w_instr[9:8];

    // State register; reset wins over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else if (!bus.stall) begin
            r_state <= w_state_next;
        end
    end

    // Next state, next PC/eff_addr and phase strobes.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_eff_next   = r_eff_addr;
        w_taken      = 1'b0;
        w_fetch      = 1'b0;
        w_exec       = 1'b0;
        w_wreg       = 1'b0;
        w_wram       = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_fetch      = 1'b1;
                w_state_next = S_DECODE;
            end
            S_DECODE: begin
                w_eff_next = r_operand;
                if (r_opcode == OP_HALT)
                    w_state_next = S_HALT;
                else if (r_addr_mode == MODE_INDIRECT)
                    w_state_next = S_INDIRECT;
                else
                    w_state_next = S_EXECUTE;
            end
            S_INDIRECT: begin
                w_eff_next   = 8'(w_ram_data);
                w_state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                w_exec = 1'b1;
                case (r_opcode)
                    OP_JMP:  w_taken = 1'b1;
                    OP_JZ:   w_taken = bus.zero_flag;
                    OP_JNZ:  w_taken = ~bus.zero_flag;
                    OP_JC:   w_taken = bus.carry_flag;
                    OP_JS:   w_taken = bus.sign_flag;
                    default: w_taken = 1'b0;
                endcase
                if (r_opcode >= 4'h1 && r_opcode <= 4'h7) begin
                    w_state_next = S_WRITEBACK;
                end else begin
                    w_state_next = S_FETCH;
                    if (w_taken)
                        w_pc_next = (r_addr_mode == MODE_INDIRECT) ?
                                    ROM_ADDR_WIDTH'(r_eff_addr) :
                                    ROM_ADDR_WIDTH'(r_operand);
                    else
                        w_pc_next = r_pc + ROM_ADDR_WIDTH'(1);
                end
            end
            S_WRITEBACK: begin
                if (r_opcode == OP_STORE) w_wram = 1'b1;
                else                      w_wreg = 1'b1;
                w_pc_next    = r_pc + ROM_ADDR_WIDTH'(1);
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: w_state_next = S_FETCH;
        endcase
        // Strobes stay quiet while reset is held.
        if (rst) begin
            w_taken  = 1'b0;
            w_fetch  = 1'b0;
            w_exec   = 1'b0;
            w_wreg   = 1'b0;
            w_wram   = 1'b0;
            w_halted = 1'b0;
        end
    end

    // PC, instruction fields and effective address; all frozen under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= '0;
            r_opcode    <= '0;
            r_addr_mode <= '0;
            r_operand   <= '0;
            r_eff_addr  <= '0;
        end else if (!bus.stall) begin
            r_pc       <= w_pc_next;
            r_eff_addr <= w_eff_next;
            if (r_state == S_FETCH) begin
                r_opcode    <= w_instr[15:12];
                r_addr_mode <= w_instr[11:10];
                r_operand   <= w_instr[7:0];
            end
        end
    end

    assign bus.rom_addr      = r_pc;
    assign bus.opcode        = r_opcode;
    assign bus.addr_mode     = r_addr_mode;
    assign bus.operand       = r_operand;
    assign bus.eff_addr      = r_eff_addr;
    assign bus.fetch_ena     = w_fetch;
    assign bus.execute_ena   = w_exec;
    assign bus.jump_ena      = w_taken;
    assign bus.write_reg_ena = w_wreg;
    assign bus.write_ram_ena = w_wram;
    assign bus.halted        = w_halted;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction timing, jumps, wrap, stall, reset, halt.
module tb_cpu_sequencer;
    logic clk;
    logic rst;
    logic [15:0] rom [256];
    int n_cmp;
    int n_bad;

    cpu_sequencer_if bus ();

    cpu_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {fetch, execute, jump, write_reg, write_ram}
    function automatic logic [4:0] strobes();
        return {bus.fetch_ena, bus.execute_ena, bus.jump_ena,
                bus.write_reg_ena, bus.write_ram_ena};
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h3005;   // ADD imm 5
        rom[8'h01] = 16'h2C20;   // STORE indirect 0x20
        rom[8'h02] = 16'hA010;   // JZ 0x10
        rom[8'h10] = 16'hA010;   // JZ 0x10 (self loop)
        rom[8'h11] = 16'h9C30;   // JMP indirect via 0x30
        rom[8'hFE] = 16'h3001;   // ADD imm 1
        rom[8'hFF] = 16'h0000;   // NOP
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.zero_flag = 1'b0;
        bus.sign_flag = 1'b0;
        bus.carry_flag = 1'b0;
        bus.ram_data = 8'h00;

        tick(); tick();
        chk("rst_strobes", 32'(strobes()), 32'h0);
        chk("rst_pc", 32'(bus.rom_addr), 32'h0);
        chk("rst_opcode", 32'(bus.opcode), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);

        // ADD imm: 4 cycles
        rst = 1'b0; #1;
        chk("add_c0_fetch", 32'(strobes()), 32'b10000);
        chk("add_c0_pc", 32'(bus.rom_addr), 32'h0);
        tick();
        chk("add_c1_opcode", 32'(bus.opcode), 32'h3);
        chk("add_c1_operand", 32'(bus.operand), 32'h05);
        chk("add_c1_strobes", 32'(strobes()), 32'b00000);
        tick();
        chk("add_c2_exec", 32'(strobes()), 32'b01000);
        tick();
        chk("add_c3_wreg", 32'(strobes()), 32'b00010);
        tick();
        chk("add_c4_fetch", 32'(strobes()), 32'b10000);
        chk("add_c4_pc", 32'(bus.rom_addr), 32'h1);

        // STORE indirect: 5 cycles, pointer 0x47
        bus.ram_data = 8'h47;
        tick();
        chk("st_mode", 32'(bus.addr_mode), 32'h3);
        chk("st_operand", 32'(bus.operand), 32'h20);
        tick();
        chk("st_ind_eff", 32'(bus.eff_addr), 32'h20);
        chk("st_ind_strobes", 32'(strobes()), 32'b00000);
        tick();
        chk("st_exec", 32'(strobes()), 32'b01000);
        chk("st_eff", 32'(bus.eff_addr), 32'h47);
        tick();
        chk("st_wram", 32'(strobes()), 32'b00001);
        tick();
        chk("st_pc", 32'(bus.rom_addr), 32'h2);

        // JZ taken
        bus.zero_flag = 1'b1;
        tick(); tick();
        chk("jz_taken", 32'(strobes()), 32'b01100);
        tick();
        chk("jz_taken_pc", 32'(bus.rom_addr), 32'h10);
        // JZ to itself
        tick(); tick();
        chk("jz_self_exec", 32'(strobes()), 32'b01100);
        tick();
        chk("jz_self_pc", 32'(bus.rom_addr), 32'h10);
        // JZ not taken
        bus.zero_flag = 1'b0;
        tick(); tick();
        chk("jz_not_taken", 32'(strobes()), 32'b01000);
        tick();
        chk("jz_nt_pc", 32'(bus.rom_addr), 32'h11);

        // JMP indirect through pointer 0xFE
        bus.ram_data = 8'hFE;
        tick(); tick(); tick();
        chk("jmpi_exec", 32'(strobes()), 32'b01100);
        chk("jmpi_eff", 32'(bus.eff_addr), 32'hFE);
        tick();
        chk("jmpi_pc", 32'(bus.rom_addr), 32'hFE);

        // ADD at 0xFE with a 3-cycle stall in writeback
        tick(); tick(); tick();
        chk("stall_wb_entry", 32'(strobes()), 32'b00010);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_wreg", 32'(strobes()), 32'b00010);
            chk("stall_pc", 32'(bus.rom_addr), 32'hFE);
        end
        bus.stall = 1'b0;
        tick();
        chk("stall_resume_fetch", 32'(strobes()), 32'b10000);
        chk("stall_resume_pc", 32'(bus.rom_addr), 32'hFF);

        // NOP at 0xFF wraps
        tick(); tick();
        chk("nop_exec", 32'(strobes()), 32'b01000);
        tick();
        chk("nop_wrap_pc", 32'(bus.rom_addr), 32'h00);

        // ADD at 0, then reset during stalled INDIRECT of STORE at 1
        tick(); tick(); tick(); tick();
        chk("add2_pc", 32'(bus.rom_addr), 32'h1);
        tick(); tick();
        chk("st2_ind_eff", 32'(bus.eff_addr), 32'h20);
        bus.stall = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_stall_pc", 32'(bus.rom_addr), 32'h0);
        chk("rst_stall_strobes", 32'(strobes()), 32'b00000);
        chk("rst_stall_eff", 32'(bus.eff_addr), 32'h0);
        chk("rst_stall_operand", 32'(bus.operand), 32'h0);
        chk("rst_stall_mode", 32'(bus.addr_mode), 32'h0);
        bus.stall = 1'b0;
        rom[8'h01] = 16'hF000;   // HALT
        rst = 1'b0; #1;
        chk("rst_release_fetch", 32'(strobes()), 32'b10000);

        // ADD at 0 then HALT at 1
        tick(); tick(); tick(); tick();
        chk("halt_fetch_pc", 32'(bus.rom_addr), 32'h1);
        tick();
        chk("halt_decode_halted", 32'(bus.halted), 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_halted", 32'(bus.halted), 32'h1);
            chk("halt_strobes", 32'(strobes()), 32'b00000);
            chk("halt_pc", 32'(bus.rom_addr), 32'h1);
        end
        rst = 1'b1;
        tick();
        chk("halt_rst_halted", 32'(bus.halted), 32'h0);
        chk("halt_rst_pc", 32'(bus.rom_addr), 32'h0);
        rst = 1'b0; #1;
        chk("halt_rst_fetch", 32'(strobes()), 32'b10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
